niosiie_led_blink: RTL and testbench
====================================

# niosiie_led_blink

Parametrised Avalon-MM output PIO for the board LED bank. It is the successor to the fixed 10-bit LED port, and sits on the NIOS II/e data master behind the system interconnect. It adds:
- atomic set/clear/toggle writes;
- a per-bit blink mode driven by a shared programmable prescaler;
- a sticky status flag, so firmware can blink LEDs without CPU polling loops.

## Interface
Parameters:
- WIDTH, 10, number of output bits (1..32)
- DIV_WIDTH, 24, prescaler reload width (1..32)
- DATA_RESET, 0, reset value of DATA
- DIV_RESET, 0, reset value of BLINK_DIV

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; zero-wait-state, combinational from address
- out_port  out  WIDTH  LED drive

## Operation
Register map (word address):
- 0 DATA, R/W: output bits.
- 1 MODE, R/W: per bit, 0 = static, 1 = blink.
- 2 BLINK_DIV, R/W: prescaler reload value, DIV_WIDTH bits.
- 3 OUTSET, W: DATA |= wd. Reads return DATA.
- 4 OUTCLR, W: DATA &= ~wd. Reads return DATA.
- 5 OUTTGL, W: DATA ^= wd. Reads return DATA.
- 6 STATUS:
  - bit0 PHASE, RO.
  - bit1 WRAP, sticky, write-1-to-clear.
- 7: reserved. Reads return 0; writes are ignored.

Write and read rules:
- A write occurs when chipselect=1 and write_n=0.
- Only writedata[WIDTH-1:0] (or [DIV_WIDTH-1:0]) is used.
- Read data is zero-extended to 32 bits.

Output function: out_port = DATA & (~MODE | {WIDTH{PHASE}}).

Prescaler:
- A down-counter CNT.
- When BLINK_DIV≠0 and CNT==0: CNT<=BLINK_DIV, PHASE toggles, WRAP<=1.
- Otherwise CNT decrements.
- PHASE half-period is BLINK_DIV+1 cycles.
- BLINK_DIV==0: CNT held at 0, PHASE forced to 1, so blink bits read as static-on and WRAP never sets.

Writing BLINK_DIV:
- Loads CNT<=new value and sets PHASE<=1.
- Takes priority over a same-cycle wrap: no toggle and no WRAP set that cycle.

Writing STATUS with bit1=1 clears WRAP. If a wrap occurs in the same cycle, the set wins and WRAP stays 1.

Reset values:
- DATA=DATA_RESET, MODE=0, BLINK_DIV=DIV_RESET, CNT=DIV_RESET.
- PHASE=1, WRAP=0.
- out_port=DATA_RESET.

Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). It deasserts synchronously to clk at the integration level.

## Timing
- A register write on clock edge N is visible on out_port and readdata after edge N.
- Reads have zero latency; readdata is a pure function of address and current registers.
- A PHASE toggle is reflected on out_port in the same cycle PHASE changes.
- Back-to-back writes are accepted every cycle; no wait states and no backpressure.
- With BLINK_DIV=D, consecutive PHASE toggles are exactly D+1 cycles apart. The first toggle after a DIV write lands D+1 cycles after that write.

## Structure
- Package niosiie_led_blink_pkg:
  - address constants ADDR_DATA … ADDR_STATUS;
  - STATUS bit indices.
- Sub-module niosiie_blink_prescaler, which holds CNT, PHASE and WRAP:
  - inputs: div value, load strobe, wrap-clear strobe;
  - outputs: phase, wrap.
- Top level holds the register file, set/clear/toggle logic, read mux and output gating.

## Test plan
- Reset: hold reset_n=0 with DATA_RESET=10'h155 → out_port=10'h155, STATUS reads 32'h1, MODE reads 0.
- Atomic ops: write DATA=10'h0F0, OUTSET=10'h00F, OUTCLR=10'h030, OUTTGL=10'h300 → DATA reads 10'h3CF, out_port=10'h3CF one edge after each write.
- Blink: DATA=10'h3FF, MODE=10'h001, BLINK_DIV=3:
  - bit0 toggles every 4 cycles, bits 9:1 stay 1;
  - WRAP sets on the first toggle;
  - writing STATUS=2 clears it.
- Divider zero: BLINK_DIV=0 with MODE=10'h3FF, DATA=10'h2AA → out_port constant 10'h2AA, WRAP stays 0 for 100 cycles.
- Collisions:
  - wrap cycle coincident with a STATUS clear → WRAP=1;
  - wrap cycle coincident with a BLINK_DIV write of 5 → PHASE=1 (no toggle), next toggle 6 cycles later.
- Mid-operation reset: pulse reset_n low for 1 cycle during blinking → all registers return to reset values; no toggle until BLINK_DIV is reprogrammed (DIV_RESET=0).

Source files
------------

// File: rtl/niosiie_led_blink_pkg.sv
// Shared constants for the LED PIO: register map, status bit positions, bus widths.
package niosiie_led_blink_pkg;

    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned BUS_WIDTH  = 32;

    // Word addresses of the register map.
    typedef enum logic [ADDR_WIDTH-1:0] {
        ADDR_DATA      = 3'd0,
        ADDR_MODE      = 3'd1,
        ADDR_BLINK_DIV = 3'd2,
        ADDR_OUTSET    = 3'd3,
        ADDR_OUTCLR    = 3'd4,
        ADDR_OUTTGL    = 3'd5,
        ADDR_STATUS    = 3'd6,
        ADDR_RSVD      = 3'd7
    } reg_addr_e;

    // STATUS register bit positions.
    localparam int unsigned STATUS_PHASE_BIT = 0;
    localparam int unsigned STATUS_WRAP_BIT  = 1;

    // True when the Avalon strobes describe a write this cycle.
    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/niosiie_led_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO (zero-wait-state, no backpressure).
interface niosiie_led_blink_if;
    import niosiie_led_blink_pkg::*;

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [BUS_WIDTH-1:0]  writedata;
    logic [BUS_WIDTH-1:0]  readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/niosiie_blink_prescaler.sv
// Shared blink prescaler: down-counter CNT, PHASE square wave and sticky WRAP flag.
module niosiie_blink_prescaler #(
    parameter int unsigned DIV_WIDTH = 24,
    parameter logic [31:0] DIV_RESET = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] div_i,       // divider value in effect this edge (new value when loading)
    input  logic                 load_i,      // BLINK_DIV written this cycle
    input  logic                 wrap_clr_i,  // STATUS.WRAP write-1-to-clear
    output logic                 phase_o,
    output logic                 wrap_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic                 wrap_q, wrap_d;
    logic                 wrap_set;

    // Next-state: a divider load beats a wrap; a zero divider parks the counter with PHASE high.
    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        wrap_set = 1'b0;
        if (load_i) begin
            cnt_d   = div_i;
            phase_d = 1'b1;
        end else if (div_i == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d    = div_i;
            phase_d  = ~phase_q;
            wrap_set = 1'b1;
        end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
        // A wrap in the same cycle as a clear keeps the flag set.
        if (wrap_set) begin
            wrap_d = 1'b1;
        end else if (wrap_clr_i) begin
            wrap_d = 1'b0;
        end else begin
            wrap_d = wrap_q;
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= DIV_WIDTH'(DIV_RESET);
            phase_q <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/niosiie_led_blink.sv
// LED bank output PIO: register file, atomic set/clear/toggle, blink gating and read mux.
module niosiie_led_blink
    import niosiie_led_blink_pkg::*;
#(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DIV_WIDTH  = 24,
    parameter logic [31:0] DATA_RESET = 32'h0,
    parameter logic [31:0] DIV_RESET  = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    niosiie_led_blink_if.slave     bus,
    output logic [WIDTH-1:0]       out_port
);

    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 div_load;
    logic                 wrap_clr;
    logic                 phase;
    logic                 wrap;
    logic                 wr_en;
    reg_addr_e            addr;
    logic [WIDTH-1:0]     wd_data;
    logic [DIV_WIDTH-1:0] wd_div;
    logic                 unused_wd;

    assign addr      = reg_addr_e'(bus.address);
    assign wr_en     = is_write(bus.chipselect, bus.write_n);
    assign wd_data   = bus.writedata[WIDTH-1:0];
    assign wd_div    = bus.writedata[DIV_WIDTH-1:0];
    // Upper write-data bits beyond WIDTH/DIV_WIDTH are intentionally dropped.
    assign unused_wd = ^bus.writedata;

    // Register write decode, including the atomic DATA update forms.
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        div_d    = div_q;
        div_load = 1'b0;
        wrap_clr = 1'b0;
        if (wr_en) begin
            case (addr)
                ADDR_DATA:      data_d = wd_data;
                ADDR_MODE:      mode_d = wd_data;
                ADDR_BLINK_DIV: begin
                    div_d    = wd_div;
                    div_load = 1'b1;
                end
                ADDR_OUTSET:    data_d = data_q | wd_data;
                ADDR_OUTCLR:    data_d = data_q & ~wd_data;
                ADDR_OUTTGL:    data_d = data_q ^ wd_data;
                ADDR_STATUS:    wrap_clr = bus.writedata[STATUS_WRAP_BIT];
                default:        ;
            endcase
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= WIDTH'(DATA_RESET);
            mode_q <= '0;
            div_q  <= DIV_WIDTH'(DIV_RESET);
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            div_q  <= div_d;
        end
    end

    // div_d carries the freshly written value on a load, otherwise the current divider.
    niosiie_blink_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_RESET (DIV_RESET)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .div_i      (div_d),
        .load_i     (div_load),
        .wrap_clr_i (wrap_clr),
        .phase_o    (phase),
        .wrap_o     (wrap)
    );

    // Zero-wait-state read mux; everything zero-extended to the bus width.
    always_comb begin
        bus.readdata = '0;
        case (addr)
            ADDR_DATA,
            ADDR_OUTSET,
            ADDR_OUTCLR,
            ADDR_OUTTGL:    bus.readdata = BUS_WIDTH'(data_q);
            ADDR_MODE:      bus.readdata = BUS_WIDTH'(mode_q);
            ADDR_BLINK_DIV: bus.readdata = BUS_WIDTH'(div_q);
            ADDR_STATUS: begin
                bus.readdata[STATUS_PHASE_BIT] = phase;
                bus.readdata[STATUS_WRAP_BIT]  = wrap;
            end
            default:        bus.readdata = '0;
        endcase
    end

    // Blink bits follow PHASE; static bits follow DATA directly.
    assign out_port = data_q & (~mode_q | {WIDTH{phase}});

endmodule

// File: tb/tb_niosiie_led_blink.sv
// Directed self-checking bench for the LED PIO.
module tb_niosiie_led_blink;
    import niosiie_led_blink_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [9:0] out_port;
    int         n_cmp;
    int         n_err;

    niosiie_led_blink_if bus ();

    niosiie_led_blink #(
        .WIDTH      (10),
        .DIV_WIDTH  (24),
        .DATA_RESET (32'h155),
        .DIV_RESET  (32'h0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge; writes land on the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic sel(input logic [2:0] a);
        bus.address = a;
        #1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        if (out_port !== 10'h155) begin n_err++; $display("FAIL reset_out: got %h want %h", out_port, 10'h155); end
        n_cmp++;
        sel(3'd6);
        if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL reset_status: got %h want %h", bus.readdata, 32'h1); end
        n_cmp++;
        sel(3'd1);
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL reset_mode: got %h want %h", bus.readdata, 32'h0); end
        n_cmp++;
        sel(3'd0);
        if (bus.readdata !== 32'h155) begin n_err++; $display("FAIL reset_data: got %h want %h", bus.readdata, 32'h155); end
        n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        if (out_port !== 10'h155) begin n_err++; $display("FAIL reset_release_out: got %h want %h", out_port, 10'h155); end
        n_cmp++;
    endtask

    task automatic test_atomic();
        logic [2:0]  at [4];
        logic [31:0] dt [4];
        logic [9:0]  et [4];
        at = '{3'd0, 3'd3, 3'd4, 3'd5};
        dt = '{32'hFFFF_F0F0, 32'h0000_000F, 32'h0000_0030, 32'hFFFF_FB00};
        et = '{10'h0F0, 10'h0FF, 10'h0CF, 10'h3CF};
        for (int i = 0; i < 4; i++) begin
            wr(at[i], dt[i]);
            if (out_port !== et[i]) begin n_err++; $display("FAIL atomic_out[%0d]: got %h want %h", i, out_port, et[i]); end
            n_cmp++;
            sel(at[i]);
            if (bus.readdata !== {22'h0, et[i]}) begin n_err++; $display("FAIL atomic_rd[%0d]: got %h want %h", i, bus.readdata, {22'h0, et[i]}); end
            n_cmp++;
        end
        sel(3'd7);
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL rsvd_rd: got %h want %h", bus.readdata, 32'h0); end
        n_cmp++;
        @(negedge clk);
        wr(3'd7, 32'hFFFF_FFFF);
        if (out_port !== 10'h3CF) begin n_err++; $display("FAIL rsvd_wr_out: got %h want %h", out_port, 10'h3CF); end
        n_cmp++;
        sel(3'd0);
        if (bus.readdata !== 32'h3CF) begin n_err++; $display("FAIL rsvd_wr_data: got %h want %h", bus.readdata, 32'h3CF); end
        n_cmp++;
        @(negedge clk);
    endtask

    task automatic test_blink();
        logic       ph;
        logic       wp;
        logic [9:0] eo;
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h001);
        wr(3'd6, 32'h2);
        wr(3'd2, 32'h3);                       // divider load on edge N
        sel(3'd6);
        if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL blink_k0_status: got %h want %h", bus.readdata, 32'h1); end
        n_cmp++;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ph = ((k / 4) % 2) == 0;
            wp = (k >= 4);
            eo = {9'h1FF, ph};
            if (out_port !== eo) begin n_err++; $display("FAIL blink_out k=%0d: got %h want %h", k, out_port, eo); end
            n_cmp++;
            if (bus.readdata !== {30'h0, wp, ph}) begin n_err++; $display("FAIL blink_status k=%0d: got %h want %h", k, bus.readdata, {30'h0, wp, ph}); end
            n_cmp++;
        end
        wr(3'd6, 32'h2);                       // clear on N+13, phase low, no wrap due
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL w1c_status: got %h want %h", bus.readdata, 32'h0); end
        n_cmp++;
        if (out_port !== 10'h3FE) begin n_err++; $display("FAIL w1c_out: got %h want %h", out_port, 10'h3FE); end
        n_cmp++;
        repeat (2) @(negedge clk);
        wr(3'd6, 32'h2);                       // clear on N+16, coincides with a wrap
        if (bus.readdata !== 32'h3) begin n_err++; $display("FAIL clr_vs_wrap_status: got %h want %h", bus.readdata, 32'h3); end
        n_cmp++;
        wr(3'd6, 32'h2);                       // N+17
        if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL clr_after_status: got %h want %h", bus.readdata, 32'h1); end
        n_cmp++;
        repeat (2) @(negedge clk);
        wr(3'd2, 32'h5);                       // divider write on N+20, coincides with a wrap
        sel(3'd6);
        if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL div_vs_wrap_status: got %h want %h", bus.readdata, 32'h1); end
        n_cmp++;
        if (out_port !== 10'h3FF) begin n_err++; $display("FAIL div_vs_wrap_out: got %h want %h", out_port, 10'h3FF); end
        n_cmp++;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            ph = (j < 6);
            eo = {9'h1FF, ph};
            if (out_port !== eo) begin n_err++; $display("FAIL div5_out j=%0d: got %h want %h", j, out_port, eo); end
            n_cmp++;
            if (bus.readdata !== {30'h0, ~ph, ph}) begin n_err++; $display("FAIL div5_status j=%0d: got %h want %h", j, bus.readdata, {30'h0, ~ph, ph}); end
            n_cmp++;
        end
    endtask

    task automatic test_div_zero();
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h2AA);
        wr(3'd6, 32'h2);
        sel(3'd6);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_port !== 10'h2AA) begin n_err++; $display("FAIL div0_out c=%0d: got %h want %h", c, out_port, 10'h2AA); end
            n_cmp++;
            if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL div0_status c=%0d: got %h want %h", c, bus.readdata, 32'h1); end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  at [4];
        logic [31:0] dt [4];
        logic [9:0]  et [4];
        wr(3'd1, 32'h0);
        at = '{3'd0, 3'd3, 3'd3, 3'd5};
        dt = '{32'h0, 32'h1, 32'h2, 32'h3FF};
        et = '{10'h000, 10'h001, 10'h003, 10'h3FC};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.address   = at[i];
            bus.writedata = dt[i];
            @(negedge clk);
            if (out_port !== et[i]) begin n_err++; $display("FAIL b2b_out[%0d]: got %h want %h", i, out_port, et[i]); end
            n_cmp++;
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        @(negedge clk);
        if (out_port !== 10'h3FC) begin n_err++; $display("FAIL b2b_hold: got %h want %h", out_port, 10'h3FC); end
        n_cmp++;
    endtask

    task automatic test_mid_reset();
        logic [2:0]  at [4];
        logic [31:0] et [4];
        wr(3'd1, 32'h001);
        wr(3'd0, 32'h3FF);
        wr(3'd2, 32'h3);
        repeat (5) @(negedge clk);
        if (out_port !== 10'h3FE) begin n_err++; $display("FAIL prereset_out: got %h want %h", out_port, 10'h3FE); end
        n_cmp++;
        reset_n = 1'b0;
        #1;
        if (out_port !== 10'h155) begin n_err++; $display("FAIL async_reset_out: got %h want %h", out_port, 10'h155); end
        n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        at = '{3'd0, 3'd1, 3'd2, 3'd6};
        et = '{32'h155, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) begin
            sel(at[i]);
            if (bus.readdata !== et[i]) begin n_err++; $display("FAIL postreset_rd[%0d]: got %h want %h", i, bus.readdata, et[i]); end
            n_cmp++;
        end
        @(negedge clk);
        wr(3'd1, 32'h3FF);
        sel(3'd6);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_port !== 10'h155) begin n_err++; $display("FAIL postreset_out c=%0d: got %h want %h", c, out_port, 10'h155); end
            n_cmp++;
            if (bus.readdata !== 32'h1) begin n_err++; $display("FAIL postreset_status c=%0d: got %h want %h", c, bus.readdata, 32'h1); end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_atomic();
        test_blink();
        test_div_zero();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
